// File: rtl/flash_loader.sv
// flash_loader: receives a byte stream (16-bit word count N, LSB first, then N 32-bit words,
// LSB first) and writes each word to the instruction flash. The CPU is held in reset until
// the load completes.
//
// Optional feature: define FLASH_LOADER_CHECKSUM_EN to require one trailing byte equal to the
// XOR of all data bytes. The load ends in err if that byte does not match.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_data/in_valid    byte stream input; a byte is accepted when in_valid && in_ready
//   in_ready            loader can take a byte this cycle
//   flash_addr/data/en  flash write port; en is a one-cycle strobe
//   cpu_rst             core reset; released only once the load is done
//   done / err          load finished / load aborted (both sticky until rst)
module flash_loader #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             flash_en,
  output logic             cpu_rst,
  output logic             done,
  output logic             err
);

  // Largest word count that fits in the flash.
  localparam int unsigned MaxWords = 1 << (ADDR_WIDTH - 2);

`ifdef FLASH_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StLenLo, StLenHi, StData, StWrite, StCheck, StDone, StErr
  } state_e;
`else
  typedef enum logic [2:0] {
    StLenLo, StLenHi, StData, StWrite, StDone, StErr
  } state_e;
`endif

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_idx_q;
  // Holds bytes 0..2 of the current word; byte 3 goes straight into flash_data.
  logic [23:0] word_q;
`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        accept;
  logic [15:0] len_full;

  assign accept   = in_valid & in_ready;
  assign len_full = {in_data, count_q[7:0]};

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      StLenLo, StLenHi, StData: in_ready = 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
      StCheck:                  in_ready = 1'b1;
`endif
      default:                  in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLenLo;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
      flash_addr <= '0;
      flash_data <= '0;
      flash_en   <= 1'b0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      flash_en <= 1'b0;
      case (state_q)
        StLenLo: begin
          if (accept) begin
            count_q[7:0] <= in_data;
            state_q      <= StLenHi;
          end
        end
        StLenHi: begin
          if (accept) begin
            count_q <= len_full;
            if (32'(len_full) > MaxWords) begin
              state_q <= StErr;
              err     <= 1'b1;
            end else if (len_full == 16'd0) begin
`ifdef FLASH_LOADER_CHECKSUM_EN
              state_q <= StCheck;
`else
              state_q <= StDone;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
`endif
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            word_q     <= {in_data, word_q[23:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef FLASH_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ in_data;
`endif
            if (byte_idx_q == 2'd3) begin
              // Strobe and payload are registered here so they are valid throughout WRITE.
              state_q    <= StWrite;
              flash_en   <= 1'b1;
              flash_data <= WIDTH'({in_data, word_q});
              flash_addr <= WIDTH'(BASE_ADDR) + WIDTH'({word_idx_q, 2'b00});
            end
          end
        end
        StWrite: begin
          word_idx_q <= word_idx_q + 16'd1;
          if ((32'(word_idx_q) + 32'd1) < 32'(count_q)) begin
            state_q <= StData;
          end else begin
`ifdef FLASH_LOADER_CHECKSUM_EN
            state_q <= StCheck;
`else
            state_q <= StDone;
            done    <= 1'b1;
            cpu_rst <= 1'b0;
`endif
          end
        end
`ifdef FLASH_LOADER_CHECKSUM_EN
        StCheck: begin
          if (accept) begin
            if (in_data == csum_q) begin
              state_q <= StDone;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state_q <= StErr;
              err     <= 1'b1;
            end
          end
        end
`endif
        StDone: state_q <= StDone;
        StErr:  state_q <= StErr;
        default: begin
          state_q <= StErr;
          err     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
module tb_flash_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] flash_addr;
  logic [31:0] flash_data;
  logic        flash_en;
  logic        cpu_rst;
  logic        done;
  logic        err;

  flash_loader #(
    .WIDTH     (32),
    .ADDR_WIDTH(11),
    .BASE_ADDR (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flash_addr(flash_addr),
    .flash_data(flash_data),
    .flash_en  (flash_en),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stream_q[$];
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_consumed;
  bit          mon_en = 1'b0;

  // Record every flash write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en && flash_en) begin
      got_addr.push_back(flash_addr);
      got_data.push_back(flash_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: parse the stream by its format rules and list the writes and final outcome.
  task automatic model();
    int n;
    logic [7:0] x;
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    n = int'(stream_q[0]) + 256 * int'(stream_q[1]);
    exp_consumed = 2;
    exp_done = 1'b0;
    exp_err = 1'b0;
    x = 8'h00;
    if (n > 512) begin
      exp_err = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++) begin
        w = w + (32'(stream_q[2 + 4 * k + b]) << (8 * b));
        x = x ^ stream_q[2 + 4 * k + b];
      end
      exp_addr.push_back(32'(4 * k));
      exp_data.push_back(w);
    end
    exp_consumed = 2 + 4 * n;
`ifdef FLASH_LOADER_CHECKSUM_EN
    exp_consumed++;
    if (stream_q[exp_consumed - 1] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endtask

  // Called at a negedge; returns at a negedge. ok=1 when the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int budget, output bit ok);
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = $urandom_range(0, 255);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_flash_en", flash_en, 0);
    check_eq("rst_flash_addr", flash_addr, 0);
    check_eq("rst_flash_data", flash_data, 0);
    check_eq("rst_cpu_rst", cpu_rst, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_in_ready", in_ready, 1);
  endtask

  task automatic run_stream(input int gap);
    bit ok;
    int acc;
    do_reset();
    got_addr.delete();
    got_data.delete();
    mon_en = 1'b1;
    acc = 0;
    foreach (stream_q[i]) begin
      send_byte(stream_q[i], 40, ok);
      if (ok) acc++;
      repeat (gap) @(negedge clk);
    end
    // Terminal states must refuse further bytes.
    send_byte(8'ha5, 8, ok);
    check_eq("extra_byte_refused", ok, 0);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    model();
    check_eq("bytes_accepted", acc, exp_consumed);
    check_eq("write_count", got_addr.size(), exp_addr.size());
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      check_eq("write_addr", got_addr[k], exp_addr[k]);
      check_eq("write_data", got_data[k], exp_data[k]);
    end
    check_eq("final_done", done, exp_done);
    check_eq("final_err", err, exp_err);
    check_eq("final_cpu_rst", cpu_rst, !exp_done);
    check_eq("final_in_ready", in_ready, 0);
    check_eq("final_flash_en", flash_en, 0);
  endtask

  task automatic build_stream(input int n, input bit with_words, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    stream_q.delete();
    stream_q.push_back(8'(n));
    stream_q.push_back(8'(n >> 8));
    if (!with_words) return;
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = $urandom_range(0, 255);
      x = x ^ b;
      stream_q.push_back(b);
    end
`ifdef FLASH_LOADER_CHECKSUM_EN
    if (corrupt) x = x ^ 8'(1 << $urandom_range(0, 7));
    stream_q.push_back(x);
`endif
  endtask

  task automatic load_ref_stream(input logic [7:0] trailer);
    stream_q = '{8'h03, 8'h00, 8'h33, 8'h46, 8'hc6, 8'h00, 8'h13, 8'h06,
                 8'h16, 8'h00, 8'h6f, 8'hf0, 8'hdf, 8'hff};
`ifdef FLASH_LOADER_CHECKSUM_EN
    stream_q.push_back(trailer);
`else
    if (trailer == 8'hff) stream_q.push_back(8'h00);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    repeat (2) @(negedge clk);

    // Reference stream, back-to-back and with 5-cycle gaps.
    for (int g = 0; g <= 5; g += 5) begin
      load_ref_stream(8'h0f);
      run_stream(g);
      if (got_addr.size() == 3) begin
        check_eq("ref_addr0", got_addr[0], 32'h000);
        check_eq("ref_data0", got_data[0], 32'h00c64633);
        check_eq("ref_addr1", got_addr[1], 32'h004);
        check_eq("ref_data1", got_data[1], 32'h00160613);
        check_eq("ref_addr2", got_addr[2], 32'h008);
        check_eq("ref_data2", got_data[2], 32'hffdff06f);
      end
      check_eq("ref_done", done, 1);
    end

    // Oversized count: ERR right after the header.
    stream_q = '{8'h01, 8'h02};
    run_stream(0);
    check_eq("big_n_err", err, 1);

    // Zero words.
    build_stream(0, 1'b1, 1'b0);
    run_stream(1);
    check_eq("zero_n_done", done, 1);

    // Count boundaries: 512 fits, 513 does not.
    build_stream(512, 1'b1, 1'b0);
    run_stream(0);
    check_eq("n512_done", done, 1);
    stream_q = '{8'h01, 8'h02};
    stream_q[0] = 8'h01;
    stream_q[1] = 8'h02;
    build_stream(513, 1'b0, 1'b0);
    run_stream(0);
    check_eq("n513_err", err, 1);

    // Reset after 6 bytes, then a full resend.
    do_reset();
    load_ref_stream(8'h0f);
    for (int i = 0; i < 6; i++) send_byte(stream_q[i], 40, ok);
    run_stream(0);

`ifdef FLASH_LOADER_CHECKSUM_EN
    load_ref_stream(8'h0e);
    run_stream(0);
    check_eq("bad_csum_writes", got_addr.size(), 3);
    check_eq("bad_csum_err", err, 1);
`endif

    // Reset landing in WRITE aborts the strobe.
    do_reset();
    build_stream(1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(stream_q[i], 40, ok);
    check_eq("write_strobe", flash_en, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("write_abort_en", flash_en, 0);
    check_eq("write_abort_data", flash_data, 0);
    rst = 1'b0;

    // Randomized streams.
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        n = $urandom_range(513, 65535);
        build_stream(n, 1'b0, 1'b0);
      end else begin
        n = $urandom_range(0, 8);
        build_stream(n, 1'b1, $urandom_range(0, 3) == 0);
      end
      run_stream($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 32: flash data word width in bits; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11: byte-address width of the instruction flash.
REQ-003 SHALL have parameter BASE_ADDR, default 0: byte address of the first word written.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, 8: one byte of the load stream.
REQ-007 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1: a byte is accepted on any cycle with in_valid=1 and in_ready=1.
REQ-009 SHALL have port flash_addr, output, WIDTH: byte address of the current flash write.
REQ-010 SHALL have port flash_data, output, WIDTH: instruction word of the current flash write.
REQ-011 SHALL have port flash_en, output, 1: one-cycle write strobe for the flash port.
REQ-012 SHALL have port cpu_rst, output, 1: holds the core in reset until the load completes.
REQ-013 SHALL have port done, output, 1: load completed successfully.
REQ-014 SHALL have port err, output, 1: load aborted.

Function
REQ-015 The stream format SHALL be: word count N as 2 bytes, LSB first; then N words of 4 bytes each, LSB first.
REQ-016 The FSM SHALL have states LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE and ERR.
REQ-017 in_ready SHALL be 1 only in LEN_LO, LEN_HI, DATA and CHECK.
REQ-018 LEN_LO SHALL go to LEN_HI on an accepted byte; LEN_HI SHALL go to DATA on an accepted byte.
REQ-019 If N > 2^(ADDR_WIDTH-2), the FSM SHALL enter ERR instead of DATA in the cycle after the LEN_HI byte is accepted.
REQ-020 If N = 0, the FSM SHALL go from LEN_HI to CHECK with the macro defined, and to DONE without it.
REQ-021 DATA SHALL place accepted byte i (i = 0..3) into bits [8i+7:8i] of a word register.
REQ-022 The FSM SHALL enter WRITE in the cycle after the 4th byte is accepted.
REQ-023 WRITE SHALL last exactly 1 cycle with flash_en=1, flash_data = assembled word, and flash_addr = BASE_ADDR + 4*k, where k is the 0-based word index.
REQ-024 After WRITE the FSM SHALL go to DATA if k+1 < N, otherwise to CHECK with the macro defined or to DONE without it.
REQ-025 flash_en SHALL be 0 in every state other than WRITE; flash_addr and flash_data SHALL hold their last values outside WRITE.
REQ-026 In DONE: done=1, cpu_rst=0, in_ready=0; the FSM SHALL stay in DONE until rst.
REQ-027 In ERR: err=1, cpu_rst=1, in_ready=0, flash_en=0; the FSM SHALL stay in ERR until rst.
REQ-028 Bytes presented while in_ready=0 SHALL NOT be consumed, and in_valid gaps of any length SHALL NOT corrupt state.
REQ-029 cpu_rst SHALL be 1 in every state except DONE.

Reset
REQ-030 While rst=1 at a posedge, the FSM SHALL go to LEN_LO and the following SHALL be cleared: word index, byte index, count, word register and checksum.
REQ-031 Reset values SHALL be: flash_en=0, flash_addr=0, flash_data=0, cpu_rst=1, done=0, err=0.
REQ-032 A reset during any state, including WRITE, SHALL abort that cycle's write, so flash_en=0 in the following cycle.

Configuration
REQ-033 With FLASH_LOADER_CHECKSUM_EN defined, the loader SHALL maintain the XOR of all data bytes and, in CHECK, SHALL accept one trailing byte.
REQ-034 In CHECK, the FSM SHALL go to DONE if the trailing byte equals the running XOR, otherwise to ERR.
REQ-035 Without FLASH_LOADER_CHECKSUM_EN, the CHECK state and checksum logic SHALL be absent and no trailing byte SHALL be consumed.

Verification
REQ-036 Stream 03 00 33 46 c6 00 13 06 16 00 6f f0 df ff (+0F when the macro is on) -> three flash_en pulses: (0x000, 0x00c64633), (0x004, 0x00160613), (0x008, 0xffdff06f), then done=1 and cpu_rst=0.
REQ-037 Same stream with in_valid deasserted for 5 cycles between every byte -> identical writes, addresses and final state.
REQ-038 Stream 01 02 -> err=1, cpu_rst=1, no flash_en pulse, in_ready=0 (N=0x0201 > 512).
REQ-039 rst asserted for 1 cycle after the 6th byte of the REQ-036 stream, then the full stream resent -> exactly one pulse per word after the reset, and the writes from REQ-036.
REQ-040 Macro on, REQ-036 stream with trailing byte 0x0E -> all three writes occur, then err=1, done=0, cpu_rst=1.
REQ-041 Stream 00 00 -> done=1 with zero flash_en pulses (macro on: after trailing byte 00).
